// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS32 control FSM: sequences memory, ALU, register file and PC with ready-handshake stalls.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mips_multicycle_ctrl #(
    parameter int CNT_WIDTH  = 32,
    parameter int WAIT_LIMIT = 0
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] PCSrc,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count
`endif
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam int WW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    state_e          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            limit_hit;

    // Limit is reached once WAIT_LIMIT stall cycles have already elapsed; ready still wins here.
    assign limit_hit = (WAIT_LIMIT > 0) && !mem_ready && (wait_q == WW'(WAIT_LIMIT));
    assign state     = state_q;

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUControl  = 3'b000;
        PCSrc       = 2'b00;
        pc_en       = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = mem_ready;
                pc_en      = mem_ready;
                if (mem_ready)      state_d = S_DECODE;
                else if (limit_hit) mem_timeout = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
                else if (limit_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                else if (limit_hit) begin
                    mem_timeout = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                state_d = S_ALUWB;
                case (funct)
                    6'b100000: ALUControl = ALU_ADD;
                    6'b100010: ALUControl = ALU_SUB;
                    6'b100100: ALUControl = ALU_AND;
                    6'b100101: ALUControl = ALU_OR;
                    6'b101010: ALUControl = ALU_SLT;
                    default: begin
                        ALUControl = ALU_ADD;
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                pc_en      = zero;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_ADD;
                state_d    = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // A timeout in FETCH stays in FETCH, so the abort itself must also clear the count.
        if (state_d != state_q || mem_timeout)
            wait_d = '0;
        else if (!mem_ready && (state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR))
            wait_d = wait_q + 1'b1;
        else
            wait_d = wait_q;
    end

`ifdef MC_PERF_CNT_EN
    logic retire;
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_ADDIWB) ||
                    (state_q == S_BRANCH) || (state_q == S_JUMP) ||
                    (state_q == S_MEMWR && mem_ready);

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            cycle_count <= cycle_count + 1'b1;
            if (retire) instr_count <= instr_count + 1'b1;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = CNT_WIDTH[0];
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: stimulus queues per-cycle expected state/controls,
// a negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUControl;
        logic [1:0] PCSrc;
        logic       pc_en, illegal_op, mem_timeout;
    } ctrl_t;

    typedef struct {
        string      name;
        logic [3:0] st;
        ctrl_t      c;
    } exp_t;

    localparam ctrl_t C_FETCH_S = '{MemRead:1'b1, ALUSrcB:2'b01, ALUControl:3'b010, default:'0};
    localparam ctrl_t C_FETCH_R = '{MemRead:1'b1, ALUSrcB:2'b01, ALUControl:3'b010,
                                    IRWrite:1'b1, pc_en:1'b1, default:'0};
    localparam ctrl_t C_DECODE  = '{ALUSrcB:2'b11, ALUControl:3'b010, default:'0};
    localparam ctrl_t C_DEC_ILL = '{ALUSrcB:2'b11, ALUControl:3'b010, illegal_op:1'b1, default:'0};
    localparam ctrl_t C_MEMADR  = '{ALUSrcA:1'b1, ALUSrcB:2'b10, ALUControl:3'b010, default:'0};
    localparam ctrl_t C_MEMRD   = '{IorD:1'b1, MemRead:1'b1, default:'0};
    localparam ctrl_t C_MEMRD_T = '{IorD:1'b1, MemRead:1'b1, mem_timeout:1'b1, default:'0};
    localparam ctrl_t C_MEMWB   = '{MemtoReg:1'b1, RegWrite:1'b1, default:'0};
    localparam ctrl_t C_MEMWR   = '{IorD:1'b1, MemWrite:1'b1, default:'0};
    localparam ctrl_t C_EX_SLT  = '{ALUSrcA:1'b1, ALUControl:3'b111, default:'0};
    localparam ctrl_t C_EX_SUB  = '{ALUSrcA:1'b1, ALUControl:3'b110, default:'0};
    localparam ctrl_t C_EX_ILL  = '{ALUSrcA:1'b1, ALUControl:3'b010, illegal_op:1'b1, default:'0};
    localparam ctrl_t C_ALUWB   = '{RegDst:1'b1, RegWrite:1'b1, default:'0};
    localparam ctrl_t C_BR_T    = '{ALUSrcA:1'b1, ALUControl:3'b110, PCSrc:2'b01, pc_en:1'b1, default:'0};
    localparam ctrl_t C_BR_NT   = '{ALUSrcA:1'b1, ALUControl:3'b110, PCSrc:2'b01, default:'0};
    localparam ctrl_t C_ADDIWB  = '{RegWrite:1'b1, default:'0};
    localparam ctrl_t C_JUMP    = '{PCSrc:2'b10, pc_en:1'b1, default:'0};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    logic       clock = 1'b1;
    logic       Reset = 1'b1;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic       pc_en, illegal_op, mem_timeout;
    logic [3:0] state;
    ctrl_t      act;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_count, instr_count, ic0;
    int          ncyc;
    always @(posedge clock or posedge Reset)
        if (Reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
`endif

    always #5 clock = ~clock;

    mips_multicycle_ctrl #(.CNT_WIDTH(32), .WAIT_LIMIT(4)) dut (
        .clock(clock), .Reset(Reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc),
        .pc_en(pc_en), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
`ifdef MC_PERF_CNT_EN
        , .cycle_count(cycle_count), .instr_count(instr_count)
`endif
    );

    assign act = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                  ALUSrcB, ALUControl, PCSrc, pc_en, illegal_op, mem_timeout};

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (state !== e.st || act !== e.c) begin
                errors++;
                $display("FAIL %s: got state %0d ctrl %05h, expected state %0d ctrl %05h",
                         e.name, state, act, e.st, e.c);
            end
        end
    end

    task automatic cyc(input string nm, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic rdy, input logic [3:0] st, input ctrl_t c);
        exp_t e;
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        e.name = nm; e.st = st; e.c = c;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        cyc("reset", LW, 6'd0, 0, 0, 4'd0, C_FETCH_S);
        Reset = 1'b0;

        // lw, no wait states: 5 cycles
        cyc("lw_fetch",  LW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("lw_decode", LW, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("lw_memadr", LW, 6'd0, 0, 1, 4'd2, C_MEMADR);
        cyc("lw_memrd",  LW, 6'd0, 0, 1, 4'd3, C_MEMRD);
        cyc("lw_memwb",  LW, 6'd0, 0, 1, 4'd4, C_MEMWB);

        // sw with 3 stall cycles in MEMWR: 7 cycles
        cyc("sw_fetch",  SW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("sw_decode", SW, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("sw_memadr", SW, 6'd0, 0, 0, 4'd2, C_MEMADR);
        for (int i = 0; i < 3; i++) cyc("sw_stall", SW, 6'd0, 0, 0, 4'd5, C_MEMWR);
        cyc("sw_done",   SW, 6'd0, 0, 1, 4'd5, C_MEMWR);

        cyc("slt_fetch", RT, 6'b101010, 0, 1, 4'd0, C_FETCH_R);
        cyc("slt_dec",   RT, 6'b101010, 0, 1, 4'd1, C_DECODE);
        cyc("slt_exec",  RT, 6'b101010, 0, 1, 4'd6, C_EX_SLT);
        cyc("slt_wb",    RT, 6'b101010, 0, 1, 4'd7, C_ALUWB);

        cyc("sub_fetch", RT, 6'b100010, 0, 1, 4'd0, C_FETCH_R);
        cyc("sub_dec",   RT, 6'b100010, 0, 1, 4'd1, C_DECODE);
        cyc("sub_exec",  RT, 6'b100010, 0, 1, 4'd6, C_EX_SUB);
        cyc("sub_wb",    RT, 6'b100010, 0, 1, 4'd7, C_ALUWB);

        cyc("badfn_fetch", RT, 6'b000111, 0, 1, 4'd0, C_FETCH_R);
        cyc("badfn_dec",   RT, 6'b000111, 0, 1, 4'd1, C_DECODE);
        cyc("badfn_exec",  RT, 6'b000111, 0, 1, 4'd6, C_EX_ILL);

        cyc("beqt_fetch",  BEQ, 6'd0, 1, 1, 4'd0, C_FETCH_R);
        cyc("beqt_dec",    BEQ, 6'd0, 1, 1, 4'd1, C_DECODE);
        cyc("beqt_branch", BEQ, 6'd0, 1, 1, 4'd8, C_BR_T);
        cyc("beqn_fetch",  BEQ, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("beqn_dec",    BEQ, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("beqn_branch", BEQ, 6'd0, 0, 1, 4'd8, C_BR_NT);

        cyc("badop_fetch", BAD, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("badop_dec",   BAD, 6'd0, 0, 1, 4'd1, C_DEC_ILL);

        cyc("addi_fetch", ADDI, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("addi_dec",   ADDI, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("addi_ex",    ADDI, 6'd0, 0, 1, 4'd9, C_MEMADR);
        cyc("addi_wb",    ADDI, 6'd0, 0, 1, 4'd10, C_ADDIWB);

        cyc("j_fstall", J, 6'd0, 0, 0, 4'd0, C_FETCH_S);
        cyc("j_fetch",  J, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("j_dec",    J, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("j_jump",   J, 6'd0, 0, 1, 4'd11, C_JUMP);

`ifdef MC_PERF_CNT_EN
        ic0 = instr_count;
`endif
        // lw with mem_ready stuck low: 4 stall cycles, then timeout pulse
        cyc("to_fetch",  LW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("to_dec",    LW, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("to_memadr", LW, 6'd0, 0, 0, 4'd2, C_MEMADR);
        for (int i = 0; i < 4; i++) cyc("to_stall", LW, 6'd0, 0, 0, 4'd3, C_MEMRD);
        cyc("to_pulse",  LW, 6'd0, 0, 0, 4'd3, C_MEMRD_T);
        cyc("to_back",   LW, 6'd0, 0, 0, 4'd0, C_FETCH_S);
`ifdef MC_PERF_CNT_EN
        checks++;
        if (instr_count !== ic0) begin
            errors++;
            $display("FAIL perf_instr_timeout: got %0d, expected %0d", instr_count, ic0);
        end
        checks++;
        if (cycle_count !== 32'(ncyc)) begin
            errors++;
            $display("FAIL perf_cycles: got %0d, expected %0d", cycle_count, ncyc);
        end
`endif

        // mem_ready arriving exactly at the limit beats the timeout
        cyc("lim_fetch",  LW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("lim_dec",    LW, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("lim_memadr", LW, 6'd0, 0, 0, 4'd2, C_MEMADR);
        for (int i = 0; i < 4; i++) cyc("lim_stall", LW, 6'd0, 0, 0, 4'd3, C_MEMRD);
        cyc("lim_ready",  LW, 6'd0, 0, 1, 4'd3, C_MEMRD);
        cyc("lim_memwb",  LW, 6'd0, 0, 1, 4'd4, C_MEMWB);

        // Reset in the middle of a stalled store
        cyc("rs_fetch",  SW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("rs_dec",    SW, 6'd0, 0, 1, 4'd1, C_DECODE);
        cyc("rs_memadr", SW, 6'd0, 0, 0, 4'd2, C_MEMADR);
        cyc("rs_memwr",  SW, 6'd0, 0, 0, 4'd5, C_MEMWR);
        Reset = 1'b1;
        cyc("rs_async",  SW, 6'd0, 0, 0, 4'd0, C_FETCH_S);
        Reset = 1'b0;
        cyc("rs_after",  SW, 6'd0, 0, 1, 4'd0, C_FETCH_R);
        cyc("rs_dec2",   SW, 6'd0, 0, 1, 4'd1, C_DECODE);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
